// File: rtl/led_driver_pkg.sv
// Shared definitions for the LED PWM engine: register map, MODE bit positions
// and the per-channel LEDOUT output selector.
package led_driver_pkg;

    typedef enum logic [7:0] {
        REG_MODE    = 8'h00,
        REG_GRPPWM  = 8'h01,
        REG_GRPFREQ = 8'h02,
        REG_FADE    = 8'h03,
        REG_LEDOUT0 = 8'h04,
        REG_LEDOUT1 = 8'h05,
        REG_LEDOUT2 = 8'h06,
        REG_LEDOUT3 = 8'h07,
        REG_PWM     = 8'h10
    } reg_enum_t;

    localparam int MODE_FADE_EN = 0;
    localparam int MODE_INVRT   = 2;
    localparam int MODE_DMBLNK  = 3;
    localparam int MODE_SLEEP   = 4;

    typedef enum logic [1:0] {
        LED_OFF = 2'b00,
        LED_ON  = 2'b01,
        LED_PWM = 2'b10,
        LED_GRP = 2'b11
    } led_mode_t;

    // Address of the idx-th register in an indexed bank (LEDOUTk, PWMi).
    function automatic logic [7:0] reg_at(reg_enum_t base, int idx);
        return 8'(32'(base) + 32'(idx));
    endfunction

endpackage

// File: rtl/led_pwm_channel.sv
// One LED channel: applied duty register with glitch-free/fading update,
// duty comparator and LEDOUT output selector.
module led_pwm_channel
    import led_driver_pkg::*;
#(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [PWM_BITS-1:0] cnt,
    input  logic                period_end,
    input  logic                fade_en,
    input  logic                fade_step,
    input  logic [PWM_BITS-1:0] target,
    input  led_mode_t           mode,
    input  logic                gate,
    output logic                pre_out,
    output logic                busy
);

    logic [PWM_BITS-1:0] duty;
    logic                raw;

    // Duty only moves at a period boundary so a running period is never cut short.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            duty <= '0;
        end else if (period_end) begin
            if (!fade_en) begin
                duty <= target;
            end else if (fade_step) begin
                if (duty < target) begin
                    duty <= duty + PWM_BITS'(1);
                end else if (duty > target) begin
                    duty <= duty - PWM_BITS'(1);
                end
            end
        end
    end

    always_comb begin
        raw     = (cnt < duty);
        pre_out = 1'b0;
        case (mode)
            LED_OFF: pre_out = 1'b0;
            LED_ON:  pre_out = 1'b1;
            LED_PWM: pre_out = raw;
            LED_GRP: pre_out = raw & gate;
            default: pre_out = 1'b0;
        endcase
        busy = (duty != target);
    end

endmodule

// File: rtl/led_pwm_engine.sv
// N-channel LED PWM core: register file, PWM counter, group dim/blink counter,
// fade prescaler and registered LED outputs.
module led_pwm_engine
    import led_driver_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int PWM_BITS  = 8,
    parameter int GRP_DIV   = 2,
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 pwm_tick,
    input  logic                 reg_wr,
    input  logic [7:0]           reg_addr,
    input  logic [DATA_BITS-1:0] reg_wdata,
    output logic [DATA_BITS-1:0] reg_rdata,
    output logic [NUM_CH-1:0]    leds,
    output logic                 fade_active
);

    localparam int NUM_LO = (NUM_CH + 3) / 4;
    localparam int PRE_W  = (DATA_BITS > 16) ? DATA_BITS : 16;

    logic [DATA_BITS-1:0] mode_reg, grppwm_reg, grpfreq_reg, fade_rate_reg;
    logic [DATA_BITS-1:0] ledout_reg [NUM_LO];
    logic [DATA_BITS-1:0] pwm_reg    [NUM_CH];
    logic [DATA_BITS-1:0] rd_next;

    logic [PWM_BITS-1:0]  cnt, grp_cnt;
    logic [DATA_BITS-1:0] fade_pre;
    logic [PRE_W-1:0]     grp_pre, grp_limit;

    logic sleep, invert, fade_en, dmblnk;
    logic period_end, fade_step, gate;
    logic [NUM_CH-1:0] pre_out, busy, gated;
    logic unused_bits;

    assign sleep   = mode_reg[MODE_SLEEP];
    assign invert  = mode_reg[MODE_INVRT];
    assign fade_en = mode_reg[MODE_FADE_EN];
    assign dmblnk  = mode_reg[MODE_DMBLNK];

    // Sleep freezes every counter, so no period ever ends while asleep.
    assign period_end = pwm_tick && !sleep && (cnt == '1);
    assign fade_step  = period_end && fade_en && (fade_pre >= fade_rate_reg);
    assign grp_limit  = dmblnk ? PRE_W'(grpfreq_reg) : PRE_W'(GRP_DIV - 1);
    assign gate       = (DATA_BITS'(grp_cnt) < grppwm_reg);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mode_reg      <= '0;
            grppwm_reg    <= '0;
            grpfreq_reg   <= '0;
            fade_rate_reg <= '0;
            for (int k = 0; k < NUM_LO; k++) ledout_reg[k] <= '0;
            for (int i = 0; i < NUM_CH; i++) pwm_reg[i] <= '0;
        end else if (reg_wr) begin
            if (reg_addr == reg_at(REG_MODE, 0))    mode_reg      <= reg_wdata;
            if (reg_addr == reg_at(REG_GRPPWM, 0))  grppwm_reg    <= reg_wdata;
            if (reg_addr == reg_at(REG_GRPFREQ, 0)) grpfreq_reg   <= reg_wdata;
            if (reg_addr == reg_at(REG_FADE, 0))    fade_rate_reg <= reg_wdata;
            for (int k = 0; k < NUM_LO; k++) begin
                if (reg_addr == reg_at(REG_LEDOUT0, k)) ledout_reg[k] <= reg_wdata;
            end
            for (int i = 0; i < NUM_CH; i++) begin
                if (reg_addr == reg_at(REG_PWM, i)) pwm_reg[i] <= reg_wdata;
            end
        end
    end

    always_comb begin
        rd_next = '0;
        if (reg_addr == reg_at(REG_MODE, 0))    rd_next = mode_reg;
        if (reg_addr == reg_at(REG_GRPPWM, 0))  rd_next = grppwm_reg;
        if (reg_addr == reg_at(REG_GRPFREQ, 0)) rd_next = grpfreq_reg;
        if (reg_addr == reg_at(REG_FADE, 0))    rd_next = fade_rate_reg;
        for (int k = 0; k < NUM_LO; k++) begin
            if (reg_addr == reg_at(REG_LEDOUT0, k)) rd_next = ledout_reg[k];
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (reg_addr == reg_at(REG_PWM, i)) rd_next = pwm_reg[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt      <= '0;
            grp_cnt  <= '0;
            fade_pre <= '0;
            grp_pre  <= '0;
        end else begin
            if (pwm_tick && !sleep) cnt <= cnt + PWM_BITS'(1);
            if (period_end && fade_en) begin
                fade_pre <= fade_step ? '0 : fade_pre + DATA_BITS'(1);
            end
            // Rate is chosen by the DMBLNK value seen at each period end; g keeps its value.
            if (period_end) begin
                if (grp_pre >= grp_limit) begin
                    grp_pre <= '0;
                    grp_cnt <= grp_cnt + PWM_BITS'(1);
                end else begin
                    grp_pre <= grp_pre + PRE_W'(1);
                end
            end
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        led_pwm_channel #(.PWM_BITS(PWM_BITS)) u_ch (
            .clk        (clk),
            .reset_n    (reset_n),
            .cnt        (cnt),
            .period_end (period_end),
            .fade_en    (fade_en),
            .fade_step  (fade_step),
            .target     (pwm_reg[i][PWM_BITS-1:0]),
            .mode       (led_mode_t'(ledout_reg[i/4][2*(i%4) +: 2])),
            .gate       (gate),
            .pre_out    (pre_out[i]),
            .busy       (busy[i])
        );
    end

    // Sleep blanks before inversion, so an inverted sleeping driver shows all ones.
    assign gated = sleep ? '0 : pre_out;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            leds        <= '0;
            fade_active <= 1'b0;
            reg_rdata   <= '0;
        end else begin
            leds        <= invert ? ~gated : gated;
            fade_active <= |busy;
            reg_rdata   <= rd_next;
        end
    end

    always_comb begin
        unused_bits = ^mode_reg;
        for (int k = 0; k < NUM_LO; k++) unused_bits = unused_bits ^ (^ledout_reg[k]);
        for (int i = 0; i < NUM_CH; i++) unused_bits = unused_bits ^ (^pwm_reg[i]);
    end

endmodule
